wbx_arbiter: RTL and testbench

WBX_ARBITER -- requirements
Module: wbx_arbiter

---
 rtl/wbx_pkg.sv | 8 +
 rtl/wbx_arbiter_if.sv | 35 +++
 rtl/wbx_arb_pick.sv | 16 +
 rtl/wbx_arbiter.sv | 73 +++++++
 tb/tb_wbx_arbiter.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/wbx_pkg.sv
// wbx_pkg: shared FSM state type and bus widths for the Wishbone arbiter
package wbx_pkg;
  typedef enum logic {IDLE, BUSY} state_t;
  localparam int WBX_ADR_W = 16;
  localparam int WBX_DAT_W = 32;
  localparam int WBX_SEL_W = 4;
  localparam int WBX_CNT_W = 4;
endpackage

// File: rtl/wbx_arbiter_if.sv
// wbx_arbiter_if: master-side and interconnect-side Wishbone B4 pipelined signals of the arbiter
interface wbx_arbiter_if
  import wbx_pkg::*;
#(parameter int MASTER_NUM = 2);
  logic [MASTER_NUM-1:0]           wbm_cyc_o;
  logic [MASTER_NUM-1:0]           wbm_stb_o;
  logic [MASTER_NUM-1:0]           wbm_we_o;
  logic [MASTER_NUM*WBX_ADR_W-1:0] wbm_adr_o;
  logic [MASTER_NUM*WBX_SEL_W-1:0] wbm_sel_o;
  logic [MASTER_NUM*WBX_DAT_W-1:0] wbm_dat_o;
  logic [WBX_DAT_W-1:0]            wbm_dat_i;
  logic [MASTER_NUM-1:0]           wbm_ack_i;
  logic [MASTER_NUM-1:0]           wbm_stall_i;
  logic                            wbs_cyc_i;
  logic                            wbs_stb_i;
  logic                            wbs_we_i;
  logic [WBX_ADR_W-1:0]            wbs_adr_i;
  logic [WBX_SEL_W-1:0]            wbs_sel_i;
  logic [WBX_DAT_W-1:0]            wbs_dat_i;
  logic [WBX_DAT_W-1:0]            wbs_dat_o;
  logic                            wbs_stall_o;
  logic                            wbs_ack_o;
  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_sel_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i, wbm_stall_i,
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_sel_i, wbs_dat_i,
    input  wbs_dat_o, wbs_stall_o, wbs_ack_o
  );
  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_sel_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i, wbm_stall_i,
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_sel_i, wbs_dat_i,
    output wbs_dat_o, wbs_stall_o, wbs_ack_o
  );
endinterface

// File: rtl/wbx_arb_pick.sv
// wbx_arb_pick: first requesting index found searching upward (wrapping) from start
module wbx_arb_pick #(
  parameter int N = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] idx,
  output logic          valid
);
  always_comb begin
    idx = '0;
    for (int k = N - 1; k >= 0; k--) idx = req[(int'(start) + k) % N] ? IW'((int'(start) + k) % N) : idx;
  end
  assign valid = |req;
endmodule

// File: rtl/wbx_arbiter.sv
// wbx_arbiter: N:1 Wishbone B4 pipelined arbiter with outstanding limit; WBX_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority
module wbx_arbiter
  import wbx_pkg::*;
#(
  parameter int MASTER_NUM = 2,
  parameter int OUTSTANDING_MAX = 4
) (
  input logic wb_clk_i,
  input logic wb_rst_i,
  wbx_arbiter_if.slave bus
);
  localparam int IW = $clog2(MASTER_NUM);
  state_t state_q, state_d;
  logic [IW-1:0] grant_q, grant_d, start, pick_idx;
  logic [WBX_CNT_W-1:0] cnt_q, cnt_d;
  logic [MASTER_NUM-1:0] onehot;
  logic pick_valid, busy, full, gcyc, stb, fwd_ack, inc, dec, take;
`ifdef WBX_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] ptr_q, ptr_d;
  assign start = IW'((int'(ptr_q) + 1) % MASTER_NUM);
`else
  assign start = '0;
`endif
  wbx_arb_pick #(.N(MASTER_NUM), .IW(IW)) u_pick (
    .req(bus.wbm_cyc_o),
    .start(start),
    .idx(pick_idx),
    .valid(pick_valid)
  );
  assign busy = state_q == BUSY;
  assign full = cnt_q == WBX_CNT_W'(OUTSTANDING_MAX);
  assign gcyc = bus.wbm_cyc_o[grant_q];
  assign onehot = MASTER_NUM'(1) << grant_q;
  assign stb = busy && bus.wbm_stb_o[grant_q] && !full;
  assign fwd_ack = busy && bus.wbs_ack_o;
  assign inc = stb && !bus.wbs_stall_o;
  assign dec = fwd_ack && cnt_q != '0;
  assign take = !busy && pick_valid;
  assign bus.wbs_cyc_i = busy && gcyc;
  assign bus.wbs_stb_i = stb;
  assign bus.wbs_we_i = busy && bus.wbm_we_o[grant_q];
  assign bus.wbs_adr_i = busy ? bus.wbm_adr_o[grant_q*WBX_ADR_W +: WBX_ADR_W] : '0;
  assign bus.wbs_sel_i = busy ? bus.wbm_sel_o[grant_q*WBX_SEL_W +: WBX_SEL_W] : '0;
  assign bus.wbs_dat_i = busy ? bus.wbm_dat_o[grant_q*WBX_DAT_W +: WBX_DAT_W] : '0;
  assign bus.wbm_dat_i = bus.wbs_dat_o;
  assign bus.wbm_ack_i = fwd_ack ? onehot : '0;
  assign bus.wbm_stall_i = ~((busy && !bus.wbs_stall_o && !full) ? onehot : '0);
  always_comb begin
    state_d = busy ? (gcyc ? BUSY : IDLE) : (pick_valid ? BUSY : IDLE);
    grant_d = take ? pick_idx : grant_q;
    cnt_d = (busy && !gcyc) ? '0 : cnt_q + WBX_CNT_W'(inc) - WBX_CNT_W'(dec);
`ifdef WBX_ARB_ROUND_ROBIN_EN
    ptr_d = take ? pick_idx : ptr_q;
`endif
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      cnt_q <= '0;
`ifdef WBX_ARB_ROUND_ROBIN_EN
      ptr_q <= IW'(MASTER_NUM - 1);
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q <= cnt_d;
`ifdef WBX_ARB_ROUND_ROBIN_EN
      ptr_q <= ptr_d;
`endif
    end
  end
endmodule

// File: tb/tb_wbx_arbiter.sv
// tb_wbx_arbiter: directed scoreboard bench for wbx_arbiter (2 masters, 4 outstanding)
module tb_wbx_arbiter;
  import wbx_pkg::*;
  typedef struct packed {
    logic        we;
    logic [15:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } xfer_t;
`ifdef WBX_ARB_ROUND_ROBIN_EN
  localparam logic [1:0] REGRANT_STALL = 2'b01;
`else
  localparam logic [1:0] REGRANT_STALL = 2'b10;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  xfer_t exp_q[$];
  logic [1:0] ack_q[$];
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  wbx_arbiter_if #(.MASTER_NUM(2)) bus();
  wbx_arbiter #(.MASTER_NUM(2), .OUTSTANDING_MAX(4)) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus(bus)
  );
  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  task automatic mset(input int m, input logic cyc, input logic stb, input logic we,
                      input logic [15:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    bus.wbm_cyc_o[m] = cyc;
    bus.wbm_stb_o[m] = stb;
    bus.wbm_we_o[m] = we;
    bus.wbm_adr_o[m*16 +: 16] = adr;
    bus.wbm_dat_o[m*32 +: 32] = dat;
    bus.wbm_sel_o[m*4 +: 4] = sel;
  endtask
  always @(negedge clk) begin
    if (bus.wbs_stb_i && !bus.wbs_stall_o) begin
      if (exp_q.size() == 0) chk("accept queue", 64'(exp_q.size()), 64'd1);
      else chk("accepted xfer", {bus.wbs_we_i, bus.wbs_adr_i, bus.wbs_sel_i, bus.wbs_dat_i}, exp_q.pop_front());
    end
    if (bus.wbm_ack_i != 2'b00) begin
      if (ack_q.size() == 0) chk("ack queue", 64'(ack_q.size()), 64'd1);
      else chk("ack target", bus.wbm_ack_i, ack_q.pop_front());
    end
  end
  initial begin
    bus.wbm_cyc_o = '0;
    bus.wbm_stb_o = '0;
    bus.wbm_we_o = '0;
    bus.wbm_adr_o = '0;
    bus.wbm_sel_o = '0;
    bus.wbm_dat_o = '0;
    bus.wbs_dat_o = 32'hDEADBEEF;
    bus.wbs_stall_o = 1'b0;
    bus.wbs_ack_o = 1'b0;
    nxt;
    nxt;
    rst = 1'b0;
    @(negedge clk);
    chk("reset cyc", bus.wbs_cyc_i, 0);
    chk("reset stb", bus.wbs_stb_i, 0);
    chk("reset stall", bus.wbm_stall_i, 2'b11);
    chk("reset ack", bus.wbm_ack_i, 2'b00);
    chk("reset cnt", dut.cnt_q, 0);
    chk("dat passthrough", bus.wbm_dat_i, 32'hDEADBEEF);
    // single write from master 0
    nxt;
    mset(0, 1, 1, 1, 16'h0012, 32'hCAFE0001, 4'hF);
    exp_q.push_back({1'b1, 16'h0012, 4'hF, 32'hCAFE0001});
    @(negedge clk);
    chk("arb latency cyc", bus.wbs_cyc_i, 0);
    nxt;
    @(negedge clk);
    chk("granted cyc", bus.wbs_cyc_i, 1);
    chk("granted adr", bus.wbs_adr_i, 16'h0012);
    chk("m0 granted stall", bus.wbm_stall_i, 2'b10);
    nxt;
    mset(0, 1, 0, 1, 16'h0012, 32'hCAFE0001, 4'hF);
    bus.wbs_ack_o = 1'b1;
    ack_q.push_back(2'b01);
    @(negedge clk);
    chk("m1 stall", bus.wbm_stall_i[1], 1);
    nxt;
    bus.wbs_ack_o = 1'b0;
    mset(0, 0, 0, 0, 16'h0, 32'h0, 4'h0);
    nxt;
    // simultaneous requests and regrant
    mset(0, 1, 0, 0, 16'h0, 32'h0, 4'hF);
    mset(1, 1, 0, 0, 16'h0, 32'h0, 4'hF);
    nxt;
    @(negedge clk);
    chk("both req grant", bus.wbm_stall_i, 2'b10);
    nxt;
    mset(0, 0, 0, 0, 16'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk("owner drop cyc", bus.wbs_cyc_i, 0);
    nxt;
    mset(0, 1, 0, 0, 16'h0, 32'h0, 4'hF);
    @(negedge clk);
    chk("idle gap stall", bus.wbm_stall_i, 2'b11);
    nxt;
    @(negedge clk);
    chk("regrant", bus.wbm_stall_i, REGRANT_STALL);
    nxt;
    mset(0, 0, 0, 0, 16'h0, 32'h0, 4'h0);
    mset(1, 0, 0, 0, 16'h0, 32'h0, 4'h0);
    nxt;
    // outstanding limit with a silent slave
    mset(0, 1, 1, 1, 16'h0100, 32'h11110000, 4'hF);
    repeat (4) exp_q.push_back({1'b1, 16'h0100, 4'hF, 32'h11110000});
    nxt;
    repeat (4) begin
      @(negedge clk);
      nxt;
    end
    @(negedge clk);
    chk("full stb", bus.wbs_stb_i, 0);
    chk("full stall", bus.wbm_stall_i[0], 1);
    nxt;
    @(negedge clk);
    chk("full stb 6th", bus.wbs_stb_i, 0);
    chk("full stall 6th", bus.wbm_stall_i[0], 1);
    nxt;
    bus.wbs_ack_o = 1'b1;
    ack_q.push_back(2'b01);
    exp_q.push_back({1'b1, 16'h0100, 4'hF, 32'h11110000});
    @(negedge clk);
    chk("full during ack", bus.wbs_stb_i, 0);
    nxt;
    bus.wbs_ack_o = 1'b0;
    @(negedge clk);
    chk("fifth accepted", bus.wbs_stb_i, 1);
    nxt;
    mset(0, 0, 0, 0, 16'h0, 32'h0, 4'h0);
    nxt;
    @(negedge clk);
    chk("abort clears cnt", dut.cnt_q, 0);
    // same-cycle accept and ack, then abort with two outstanding
    nxt;
    mset(0, 1, 1, 1, 16'h0200, 32'h22220000, 4'hF);
    repeat (3) exp_q.push_back({1'b1, 16'h0200, 4'hF, 32'h22220000});
    nxt;
    @(negedge clk);
    nxt;
    @(negedge clk);
    nxt;
    bus.wbs_ack_o = 1'b1;
    ack_q.push_back(2'b01);
    @(negedge clk);
    chk("cnt before hold", dut.cnt_q, 2);
    nxt;
    bus.wbs_ack_o = 1'b0;
    mset(0, 0, 0, 0, 16'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk("same-cycle hold", dut.cnt_q, 2);
    nxt;
    nxt;
    bus.wbs_ack_o = 1'b1;
    @(negedge clk);
    chk("late ack dropped", bus.wbm_ack_i, 2'b00);
    nxt;
    @(negedge clk);
    chk("late ack cnt", dut.cnt_q, 0);
    nxt;
    bus.wbs_ack_o = 1'b0;
    mset(1, 1, 1, 0, 16'h0034, 32'h12345678, 4'h3);
    exp_q.push_back({1'b0, 16'h0034, 4'h3, 32'h12345678});
    @(negedge clk);
    chk("clean grant idle", bus.wbm_stall_i, 2'b11);
    nxt;
    @(negedge clk);
    chk("m1 granted stall", bus.wbm_stall_i, 2'b01);
    nxt;
    mset(1, 1, 0, 0, 16'h0034, 32'h12345678, 4'h3);
    bus.wbs_ack_o = 1'b1;
    bus.wbs_dat_o = 32'hA5A50034;
    ack_q.push_back(2'b10);
    @(negedge clk);
    chk("read data", bus.wbm_dat_i, 32'hA5A50034);
    nxt;
    bus.wbs_ack_o = 1'b0;
    mset(1, 0, 0, 0, 16'h0, 32'h0, 4'h0);
    nxt;
    // reset in the middle of a granted cycle
    mset(1, 1, 0, 0, 16'h0, 32'h0, 4'hF);
    nxt;
    @(negedge clk);
    chk("pre-reset cyc", bus.wbs_cyc_i, 1);
    nxt;
    rst = 1'b1;
    nxt;
    rst = 1'b0;
    bus.wbs_ack_o = 1'b1;
    @(negedge clk);
    chk("mid reset cyc", bus.wbs_cyc_i, 0);
    chk("mid reset stall", bus.wbm_stall_i, 2'b11);
    chk("mid reset grant", dut.grant_q, 0);
    chk("mid reset ack", bus.wbm_ack_i, 2'b00);
    nxt;
    bus.wbs_ack_o = 1'b0;
    mset(1, 0, 0, 0, 16'h0, 32'h0, 4'h0);
    nxt;
    nxt;
    chk("scoreboard drained", 64'(exp_q.size() + ack_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
